modbus_txn_ctrl: RTL and testbench

Transaction sequencer for the Modbus RTU slave. After the frame parser reports a complete request, it:
- qualifies the device address;
- waits for the CRC calculation and for the exception checker's verdict;
- dispatches a register read or write to the register file;
- launches the response builder/transmitter, then enforces the inter-frame silent gap before re-enabling reception.

---
 rtl/modbus_txn_ctrl_if.sv | 50 +++++
 rtl/modbus_txn_ctrl.sv | 262 ++++++++++++++++++++++++++
 tb/tb_modbus_txn_ctrl.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/modbus_txn_ctrl_if.sv
// Handshake bundle between the Modbus RTU transaction sequencer and its neighbours
// (frame parser, CRC unit, exception checker, register file, response transmitter).
//
// Modports:
//   master - the sequencer: consumes parser/CRC/exception/regfile/tx status and
//            drives rx_enable, busy, register starts, response fields, error pulses
//            and statistics counters.
//   slave  - the surrounding datapath, with the opposite directions.
interface modbus_txn_ctrl_if;
    logic [7:0]  dev_addr;
    logic        rx_message_done;
    logic [7:0]  rx_dev_addr;
    logic [7:0]  func_code;
    logic        crc_done;
    logic        exception_done;
    logic [7:0]  exception;
    logic        reg_op_done;
    logic        tx_done;

    logic        rx_enable;
    logic        busy;
    logic        reg_rd_start;
    logic        reg_wr_start;
    logic        resp_start;
    logic        resp_exc;
    logic [7:0]  resp_func;
    logic [7:0]  resp_exc_code;
    logic        frame_dropped;
    logic        timeout_err;
    logic        overrun;
    logic [15:0] frame_cnt;
    logic [15:0] crc_err_cnt;
    logic [15:0] exc_cnt;

    modport master (
        input  dev_addr, rx_message_done, rx_dev_addr, func_code, crc_done,
               exception_done, exception, reg_op_done, tx_done,
        output rx_enable, busy, reg_rd_start, reg_wr_start, resp_start, resp_exc,
               resp_func, resp_exc_code, frame_dropped, timeout_err, overrun,
               frame_cnt, crc_err_cnt, exc_cnt
    );

    modport slave (
        output dev_addr, rx_message_done, rx_dev_addr, func_code, crc_done,
               exception_done, exception, reg_op_done, tx_done,
        input  rx_enable, busy, reg_rd_start, reg_wr_start, resp_start, resp_exc,
               resp_func, resp_exc_code, frame_dropped, timeout_err, overrun,
               frame_cnt, crc_err_cnt, exc_cnt
    );
endinterface

// File: rtl/modbus_txn_ctrl.sv
// Modbus RTU slave transaction sequencer.
// Qualifies the address of a parsed request, waits for CRC and the exception verdict,
// dispatches a register read/write, launches the response and then holds the bus
// silent for the inter-frame gap before re-enabling reception.
//
// Ports:
//   clk_in   - system clock
//   rst_n_in - asynchronous reset, active low
//   bus      - modbus_txn_ctrl_if.master: all handshake, response and status signals
//
// Parameters:
//   EXC_WAIT   - cycles after crc_done to wait for exception_done (expiry = CRC fail)
//   OP_TIMEOUT - max cycles to wait for reg_op_done / tx_done
//   GAP_CYCLES - silent gap length before returning to idle (0 acts as 1)
//
// Build option: define MODBUS_STATS_EN to include the saturating frame/CRC-error/
// exception counters; otherwise those outputs are tied to zero.
module modbus_txn_ctrl #(
    parameter int unsigned EXC_WAIT   = 8,
    parameter int unsigned OP_TIMEOUT = 1024,
    parameter int unsigned GAP_CYCLES = 4000
) (
    input logic               clk_in,
    input logic               rst_n_in,
    modbus_txn_ctrl_if.master bus
);

    // One down-counter is shared by every timed state, so size it for the largest load.
    localparam int unsigned MaxAB  = (EXC_WAIT > OP_TIMEOUT) ? EXC_WAIT : OP_TIMEOUT;
    localparam int unsigned CntMax = (MaxAB > GAP_CYCLES) ? MaxAB : GAP_CYCLES;
    localparam int unsigned CntW   = (CntMax < 2) ? 1 : $clog2(CntMax + 1);

    localparam logic [CntW-1:0] ExcWaitLd = CntW'(EXC_WAIT);
    localparam logic [CntW-1:0] OpLd      = CntW'(OP_TIMEOUT);
    localparam logic [CntW-1:0] GapLd     = CntW'(GAP_CYCLES);
    localparam logic [CntW-1:0] CntOne    = CntW'(1);

    typedef enum logic [2:0] {
        StIdle,
        StWaitCrc,
        StWaitExc,
        StRegRd,
        StRegWr,
        StResp,
        StGap
    } state_e;

    state_e          r_state;
    logic [CntW-1:0] r_cnt;
    logic [7:0]      r_func;
    logic            r_bcast;

    logic            r_rx_enable;
    logic            r_busy;
    logic            r_reg_rd_start;
    logic            r_reg_wr_start;
    logic            r_resp_start;
    logic            r_resp_exc;
    logic [7:0]      r_resp_func;
    logic [7:0]      r_resp_exc_code;
    logic            r_frame_dropped;
    logic            r_timeout_err;
    logic            r_overrun;

    logic w_addr_ok;
    logic w_accept;
    logic w_cnt_last;
    logic w_exc_hit;
    logic w_crc_fail;
    logic w_exc_resp;
    logic w_is_read;
    logic w_is_write;

    assign w_addr_ok  = (bus.rx_dev_addr == bus.dev_addr) || (bus.rx_dev_addr == 8'h00);
    assign w_accept   = (r_state == StIdle) && bus.rx_message_done && w_addr_ok;
    // A load of N gives exactly N waiting cycles; loads of 0 behave as 1.
    assign w_cnt_last = (r_cnt <= CntOne);
    assign w_exc_hit  = (bus.exception != 8'h00);
    // exception_done on the final wait cycle still wins over expiry.
    assign w_crc_fail = (r_state == StWaitExc) && !bus.exception_done && w_cnt_last;
    assign w_exc_resp = (r_state == StWaitExc) && bus.exception_done && w_exc_hit && !r_bcast;
    assign w_is_read  = (r_func == 8'h03) || (r_func == 8'h04);
    assign w_is_write = (r_func == 8'h06);

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_state         <= StIdle;
            r_cnt           <= '0;
            r_func          <= 8'h00;
            r_bcast         <= 1'b0;
            r_rx_enable     <= 1'b1;
            r_busy          <= 1'b0;
            r_reg_rd_start  <= 1'b0;
            r_reg_wr_start  <= 1'b0;
            r_resp_start    <= 1'b0;
            r_resp_exc      <= 1'b0;
            r_resp_func     <= 8'h00;
            r_resp_exc_code <= 8'h00;
            r_frame_dropped <= 1'b0;
            r_timeout_err   <= 1'b0;
            r_overrun       <= 1'b0;
        end else begin
            r_reg_rd_start  <= 1'b0;
            r_reg_wr_start  <= 1'b0;
            r_resp_start    <= 1'b0;
            r_frame_dropped <= 1'b0;
            r_timeout_err   <= 1'b0;
            r_overrun       <= bus.rx_message_done && (r_state != StIdle);

            case (r_state)
                StIdle: begin
                    if (bus.rx_message_done) begin
                        r_func <= bus.func_code;
                        if (w_accept) begin
                            r_bcast     <= (bus.rx_dev_addr == 8'h00);
                            r_state     <= StWaitCrc;
                            r_busy      <= 1'b1;
                            r_rx_enable <= 1'b0;
                        end else begin
                            r_frame_dropped <= 1'b1;
                        end
                    end
                end

                StWaitCrc: begin
                    if (bus.crc_done) begin
                        r_cnt   <= ExcWaitLd;
                        r_state <= StWaitExc;
                    end
                end

                StWaitExc: begin
                    if (bus.exception_done) begin
                        if (w_exc_resp) begin
                            r_state         <= StResp;
                            r_cnt           <= OpLd;
                            r_resp_start    <= 1'b1;
                            r_resp_exc      <= 1'b1;
                            r_resp_func     <= r_func | 8'h80;
                            r_resp_exc_code <= bus.exception;
                        end else if (!w_exc_hit && w_is_write) begin
                            r_state        <= StRegWr;
                            r_cnt          <= OpLd;
                            r_reg_wr_start <= 1'b1;
                        end else if (!w_exc_hit && w_is_read && !r_bcast) begin
                            r_state        <= StRegRd;
                            r_cnt          <= OpLd;
                            r_reg_rd_start <= 1'b1;
                        end else begin
                            // Broadcast exception, broadcast read, or nothing to execute.
                            r_state <= StGap;
                            r_cnt   <= GapLd;
                        end
                    end else if (w_crc_fail) begin
                        r_frame_dropped <= 1'b1;
                        r_state         <= StGap;
                        r_cnt           <= GapLd;
                    end else begin
                        r_cnt <= r_cnt - CntOne;
                    end
                end

                StRegRd, StRegWr: begin
                    if (bus.reg_op_done) begin
                        if (r_bcast) begin
                            r_state <= StGap;
                            r_cnt   <= GapLd;
                        end else begin
                            r_state         <= StResp;
                            r_cnt           <= OpLd;
                            r_resp_start    <= 1'b1;
                            r_resp_exc      <= 1'b0;
                            r_resp_func     <= r_func;
                            r_resp_exc_code <= 8'h00;
                        end
                    end else if (w_cnt_last) begin
                        r_timeout_err <= 1'b1;
                        r_state       <= StGap;
                        r_cnt         <= GapLd;
                    end else begin
                        r_cnt <= r_cnt - CntOne;
                    end
                end

                StResp: begin
                    // RESP is the only state that sets resp_*, so clearing on its exits
                    // is the same as clearing on GAP entry.
                    if (bus.tx_done || w_cnt_last) begin
                        r_timeout_err   <= !bus.tx_done;
                        r_state         <= StGap;
                        r_cnt           <= GapLd;
                        r_resp_exc      <= 1'b0;
                        r_resp_func     <= 8'h00;
                        r_resp_exc_code <= 8'h00;
                    end else begin
                        r_cnt <= r_cnt - CntOne;
                    end
                end

                StGap: begin
                    if (w_cnt_last) begin
                        r_state     <= StIdle;
                        r_rx_enable <= 1'b1;
                        r_busy      <= 1'b0;
                        r_bcast     <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - CntOne;
                    end
                end

                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign bus.rx_enable     = r_rx_enable;
    assign bus.busy          = r_busy;
    assign bus.reg_rd_start  = r_reg_rd_start;
    assign bus.reg_wr_start  = r_reg_wr_start;
    assign bus.resp_start    = r_resp_start;
    assign bus.resp_exc      = r_resp_exc;
    assign bus.resp_func     = r_resp_func;
    assign bus.resp_exc_code = r_resp_exc_code;
    assign bus.frame_dropped = r_frame_dropped;
    assign bus.timeout_err   = r_timeout_err;
    assign bus.overrun       = r_overrun;

`ifdef MODBUS_STATS_EN
    logic [15:0] r_frame_cnt;
    logic [15:0] r_crc_err_cnt;
    logic [15:0] r_exc_cnt;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_frame_cnt   <= 16'h0000;
            r_crc_err_cnt <= 16'h0000;
            r_exc_cnt     <= 16'h0000;
        end else begin
            if (w_accept && (r_frame_cnt != 16'hFFFF)) begin
                r_frame_cnt <= r_frame_cnt + 16'h0001;
            end
            if (w_crc_fail && (r_crc_err_cnt != 16'hFFFF)) begin
                r_crc_err_cnt <= r_crc_err_cnt + 16'h0001;
            end
            if (w_exc_resp && (r_exc_cnt != 16'hFFFF)) begin
                r_exc_cnt <= r_exc_cnt + 16'h0001;
            end
        end
    end

    assign bus.frame_cnt   = r_frame_cnt;
    assign bus.crc_err_cnt = r_crc_err_cnt;
    assign bus.exc_cnt     = r_exc_cnt;
`else
    assign bus.frame_cnt   = 16'h0000;
    assign bus.crc_err_cnt = 16'h0000;
    assign bus.exc_cnt     = 16'h0000;
`endif

endmodule

// File: tb/tb_modbus_txn_ctrl.sv
// Self-checking bench for modbus_txn_ctrl. Output pulses are matched in order
// against a queue of expected events; timing and level checks are made directly.
module tb_modbus_txn_ctrl;

    localparam int unsigned ExcWait   = 8;
    localparam int unsigned OpTimeout = 40;
    localparam int unsigned GapCycles = 20;

`ifdef MODBUS_STATS_EN
    localparam bit Stats = 1'b1;
`else
    localparam bit Stats = 1'b0;
`endif

    localparam logic [2:0] EvRd   = 3'd1;
    localparam logic [2:0] EvWr   = 3'd2;
    localparam logic [2:0] EvResp = 3'd3;
    localparam logic [2:0] EvDrop = 3'd4;
    localparam logic [2:0] EvTmo  = 3'd5;
    localparam logic [2:0] EvOvr  = 3'd6;

    localparam int SelCrc = 0, SelExc = 1, SelOp = 2, SelTx = 3;
    localparam int SelRxEn = 4, SelDrop = 5, SelTmo = 6;

    typedef struct packed {
        logic [2:0] kind;
        logic       exc;
        logic [7:0] func;
        logic [7:0] code;
    } ev_t;

    logic clk_in   = 1'b0;
    logic rst_n_in = 1'b0;
    always #5 clk_in = ~clk_in;

    modbus_txn_ctrl_if bus ();

    modbus_txn_ctrl #(
        .EXC_WAIT  (ExcWait),
        .OP_TIMEOUT(OpTimeout),
        .GAP_CYCLES(GapCycles)
    ) dut (
        .clk_in  (clk_in),
        .rst_n_in(rst_n_in),
        .bus     (bus)
    );

    ev_t exp_q[$];
    int  n_checks = 0;
    int  n_pass   = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    endtask

    function automatic ev_t mk_ev(input logic [2:0] kind, input logic exc,
                                  input logic [7:0] func, input logic [7:0] code);
        ev_t e;
        e.kind = kind;
        e.exc  = exc;
        e.func = func;
        e.code = code;
        return e;
    endfunction

    task automatic observe(input ev_t ev);
        ev_t e;
        if (exp_q.size() == 0) begin
            check_eq("sb_unexpected", {12'h000, ev}, 32'h0);
        end else begin
            e = exp_q.pop_front();
            check_eq("sb_event", {12'h000, ev}, {12'h000, e});
        end
    endtask

    // Scoreboard monitor: every output pulse must match the next expected event.
    always @(negedge clk_in) begin
        if (rst_n_in) begin
            if (bus.reg_rd_start)  observe(mk_ev(EvRd, 1'b0, 8'h00, 8'h00));
            if (bus.reg_wr_start)  observe(mk_ev(EvWr, 1'b0, 8'h00, 8'h00));
            if (bus.resp_start)    observe(mk_ev(EvResp, bus.resp_exc, bus.resp_func,
                                                 bus.resp_exc_code));
            if (bus.frame_dropped) observe(mk_ev(EvDrop, 1'b0, 8'h00, 8'h00));
            if (bus.timeout_err)   observe(mk_ev(EvTmo, 1'b0, 8'h00, 8'h00));
            if (bus.overrun)       observe(mk_ev(EvOvr, 1'b0, 8'h00, 8'h00));
        end
    end

    function automatic logic sig(input int sel);
        case (sel)
            SelRxEn: return bus.rx_enable;
            SelDrop: return bus.frame_dropped;
            SelTmo:  return bus.timeout_err;
            default: return 1'b0;
        endcase
    endfunction

    // All stimulus tasks start and end on a falling edge.
    task automatic send_frame(input logic [7:0] addr, input logic [7:0] func);
        bus.rx_dev_addr     = addr;
        bus.func_code       = func;
        bus.rx_message_done = 1'b1;
        @(negedge clk_in);
        bus.rx_message_done = 1'b0;
    endtask

    task automatic pulse(input int sel);
        case (sel)
            SelCrc:  bus.crc_done       = 1'b1;
            SelExc:  bus.exception_done = 1'b1;
            SelOp:   bus.reg_op_done    = 1'b1;
            default: bus.tx_done        = 1'b1;
        endcase
        @(negedge clk_in);
        bus.crc_done       = 1'b0;
        bus.exception_done = 1'b0;
        bus.reg_op_done    = 1'b0;
        bus.tx_done        = 1'b0;
    endtask

    task automatic wait_for(input int sel, input int budget, output int cyc);
        cyc = 0;
        while (!sig(sel) && cyc < budget) begin
            @(negedge clk_in);
            cyc++;
        end
    endtask

    int cyc;

    initial begin
        bus.dev_addr        = 8'h01;
        bus.rx_message_done = 1'b0;
        bus.rx_dev_addr     = 8'h00;
        bus.func_code       = 8'h00;
        bus.crc_done        = 1'b0;
        bus.exception_done  = 1'b0;
        bus.exception       = 8'h00;
        bus.reg_op_done     = 1'b0;
        bus.tx_done         = 1'b0;

        repeat (3) @(negedge clk_in);
        check_eq("rst_rx_enable", bus.rx_enable, 1);
        check_eq("rst_busy", bus.busy, 0);
        check_eq("rst_resp_func", bus.resp_func, 0);
        check_eq("rst_frame_cnt", bus.frame_cnt, 0);
        rst_n_in = 1'b1;
        @(negedge clk_in);

        // Normal read.
        send_frame(8'h01, 8'h03);
        check_eq("rd_busy", bus.busy, 1);
        check_eq("rd_rx_enable", bus.rx_enable, 0);
        pulse(SelCrc);
        exp_q.push_back(mk_ev(EvRd, 1'b0, 8'h00, 8'h00));
        bus.exception = 8'h00;
        pulse(SelExc);
        exp_q.push_back(mk_ev(EvResp, 1'b0, 8'h03, 8'h00));
        repeat (3) @(negedge clk_in);
        pulse(SelOp);
        repeat (2) @(negedge clk_in);
        check_eq("rd_resp_func_hold", bus.resp_func, 8'h03);
        pulse(SelTx);
        check_eq("rd_gap_resp_clr", bus.resp_func, 0);
        check_eq("rd_gap_rx_enable", bus.rx_enable, 0);
        wait_for(SelRxEn, 200, cyc);
        check_eq("rd_gap_len", cyc, GapCycles);

        // Exception response.
        send_frame(8'h01, 8'h05);
        pulse(SelCrc);
        exp_q.push_back(mk_ev(EvResp, 1'b1, 8'h85, 8'h01));
        bus.exception = 8'h01;
        pulse(SelExc);
        check_eq("exc_resp_code", bus.resp_exc_code, 8'h01);
        pulse(SelTx);
        wait_for(SelRxEn, 200, cyc);
        check_eq("exc_gap_len", cyc, GapCycles);
        check_eq("exc_cnt", bus.exc_cnt, Stats ? 1 : 0);

        // Broadcast write, with an overrun frame arriving in WAIT_CRC.
        send_frame(8'h00, 8'h06);
        exp_q.push_back(mk_ev(EvOvr, 1'b0, 8'h00, 8'h00));
        send_frame(8'h01, 8'h03);
        check_eq("bc_busy_after_ovr", bus.busy, 1);
        pulse(SelCrc);
        exp_q.push_back(mk_ev(EvWr, 1'b0, 8'h00, 8'h00));
        bus.exception = 8'h00;
        pulse(SelExc);
        repeat (2) @(negedge clk_in);
        pulse(SelOp);
        check_eq("bc_no_resp_busy", bus.busy, 1);
        wait_for(SelRxEn, 200, cyc);
        check_eq("bc_gap_len", cyc, GapCycles);

        // Address mismatch.
        exp_q.push_back(mk_ev(EvDrop, 1'b0, 8'h00, 8'h00));
        send_frame(8'h02, 8'h03);
        check_eq("mis_drop_next", bus.frame_dropped, 1);
        check_eq("mis_stay_idle", bus.rx_enable, 1);
        @(negedge clk_in);
        check_eq("mis_busy", bus.busy, 0);

        // CRC failure: no exception verdict within EXC_WAIT.
        send_frame(8'h01, 8'h03);
        pulse(SelCrc);
        exp_q.push_back(mk_ev(EvDrop, 1'b0, 8'h00, 8'h00));
        wait_for(SelDrop, 100, cyc);
        check_eq("crc_wait_len", cyc, ExcWait);
        wait_for(SelRxEn, 200, cyc);
        check_eq("crc_gap_len", cyc, GapCycles);
        check_eq("crc_err_cnt", bus.crc_err_cnt, Stats ? 1 : 0);

        // exception_done on the last wait cycle wins; then register op timeout.
        send_frame(8'h01, 8'h04);
        pulse(SelCrc);
        repeat (ExcWait - 1) @(negedge clk_in);
        exp_q.push_back(mk_ev(EvRd, 1'b0, 8'h00, 8'h00));
        bus.exception = 8'h00;
        pulse(SelExc);
        check_eq("edge_exc_wins", bus.reg_rd_start, 1);
        exp_q.push_back(mk_ev(EvTmo, 1'b0, 8'h00, 8'h00));
        wait_for(SelTmo, 200, cyc);
        check_eq("tmo_len", cyc, OpTimeout);
        wait_for(SelRxEn, 200, cyc);
        check_eq("tmo_gap_len", cyc, GapCycles);

        // Overrun during RESP leaves the transaction untouched.
        send_frame(8'h01, 8'h03);
        pulse(SelCrc);
        exp_q.push_back(mk_ev(EvRd, 1'b0, 8'h00, 8'h00));
        pulse(SelExc);
        exp_q.push_back(mk_ev(EvResp, 1'b0, 8'h03, 8'h00));
        pulse(SelOp);
        exp_q.push_back(mk_ev(EvOvr, 1'b0, 8'h00, 8'h00));
        send_frame(8'h01, 8'h04);
        check_eq("ovr_busy", bus.busy, 1);
        check_eq("ovr_resp_func", bus.resp_func, 8'h03);
        pulse(SelTx);
        wait_for(SelRxEn, 200, cyc);
        check_eq("ovr_gap_len", cyc, GapCycles);

        check_eq("stat_frame_cnt", bus.frame_cnt, Stats ? 6 : 0);
        check_eq("stat_exc_cnt", bus.exc_cnt, Stats ? 1 : 0);

        // Reset while in RESP.
        send_frame(8'h01, 8'h05);
        pulse(SelCrc);
        exp_q.push_back(mk_ev(EvResp, 1'b1, 8'h85, 8'h02));
        bus.exception = 8'h02;
        pulse(SelExc);
        @(negedge clk_in);
        rst_n_in = 1'b0;
        #1;
        check_eq("arst_rx_enable", bus.rx_enable, 1);
        check_eq("arst_busy", bus.busy, 0);
        check_eq("arst_resp_exc", bus.resp_exc, 0);
        check_eq("arst_resp_func", bus.resp_func, 0);
        check_eq("arst_resp_code", bus.resp_exc_code, 0);
        check_eq("arst_exc_cnt", bus.exc_cnt, 0);
        repeat (2) @(negedge clk_in);
        rst_n_in = 1'b1;
        repeat (2) @(negedge clk_in);
        check_eq("post_rst_rx_enable", bus.rx_enable, 1);
        check_eq("post_rst_busy", bus.busy, 0);

        check_eq("sb_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Watchdog: never let the bench hang.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1);
    end

endmodule
